// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl
// Description : Game sequencer for the bar/hole dodging display. Moves the
//               bar down one row every `cyclesneeded` game ticks, moves the
//               player on button presses, and resolves the collision when the
//               bar reaches the player row. The collision result is a pass
//               (score, speed-up), a hit (lose a life, freeze) or game over.
// Ports       : dclk          system clock
//               clr           synchronous active-high reset
//               tick          one-dclk game-tick strobe
//               btn_left      debounced level, move left
//               btn_right     debounced level, move right
//               btn_start     debounced level, restart from game over
//               barpos        bar row to vga
//               holepos       hole column to vga
//               plrpos        player column to vga
//               lives         remaining lives to vga
//               cyclesneeded  ticks per bar step, to vga
//               score         clean passes since start, saturating at 255
//               game_over     high while the game is over
// Revision    : 1.0  initial release
// ============================================================================
module game_ctrl #(
   parameter int BAR_MAX        = 479,
   parameter int PLR_ROW        = 440,
   parameter int COLS           = 16,
   parameter int START_LIVES    = 3,
   parameter int START_CYCLES   = 4,
   parameter int SPEEDUP_PASSES = 4,
   parameter int HIT_TICKS      = 30
) (
   input  logic       dclk,
   input  logic       clr,
   input  logic       tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_start,
   output logic [8:0] barpos,
   output logic [3:0] holepos,
   output logic [3:0] plrpos,
   output logic [1:0] lives,
   output logic [2:0] cyclesneeded,
   output logic [7:0] score,
   output logic       game_over
);

   localparam logic [8:0] BAR_LAST    = 9'(BAR_MAX);
   localparam logic [8:0] COLLIDE_ROW = 9'(PLR_ROW);
   localparam logic [3:0] PLR_LAST    = 4'(COLS - 1);
   localparam logic [3:0] PLR_HOME    = 4'(COLS / 2);
   localparam logic [4:0] COLS_W      = 5'(COLS);
   localparam logic [1:0] LIVES_INIT  = 2'(START_LIVES);
   localparam logic [2:0] CYC_INIT    = 3'(START_CYCLES);
   localparam logic [7:0] PASS_LIMIT  = 8'(SPEEDUP_PASSES);
   localparam logic [7:0] HIT_LIMIT   = 8'(HIT_TICKS);
   localparam logic [7:0] LFSR_SEED   = 8'hA5;

   typedef enum logic [1:0] {
      ST_PLAY = 2'd0,
      ST_HIT  = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [8:0] barpos_nxt;
   logic [3:0] holepos_nxt, plrpos_nxt;
   logic [1:0] lives_nxt;
   logic [2:0] cyc_nxt;
   logic [7:0] score_nxt;
   logic       game_over_nxt;
   logic [2:0] tick_cnt, tick_cnt_nxt;
   logic [7:0] pass_cnt, pass_cnt_nxt;
   logic [7:0] hit_cnt, hit_cnt_nxt;
   logic [7:0] lfsr, lfsr_nxt;
   logic       left_q, right_q, start_q;

   logic       left_rise, right_rise, start_rise;
   logic [8:0] bar_step;
   logic [4:0] hole_raw;
   logic [3:0] new_hole;

   assign left_rise  = btn_left  & ~left_q;
   assign right_rise = btn_right & ~right_q;
   assign start_rise = btn_start & ~start_q;
   assign bar_step   = (barpos == BAR_LAST) ? 9'd0 : barpos + 9'd1;

   // Fold the 4-bit LFSR slice into 0..COLS-1 with a single subtraction.
   assign hole_raw = {1'b0, lfsr[3:0]};
   assign new_hole = (hole_raw >= COLS_W) ? 4'(hole_raw - COLS_W) : hole_raw[3:0];

   always_ff @(posedge dclk) begin
      if (clr) begin
         state        <= ST_PLAY;
         barpos       <= 9'd0;
         holepos      <= 4'd0;
         plrpos       <= PLR_HOME;
         lives        <= LIVES_INIT;
         cyclesneeded <= CYC_INIT;
         score        <= 8'd0;
         game_over    <= 1'b0;
         tick_cnt     <= 3'd0;
         pass_cnt     <= 8'd0;
         hit_cnt      <= 8'd0;
         lfsr         <= LFSR_SEED;
         left_q       <= 1'b0;
         right_q      <= 1'b0;
         start_q      <= 1'b0;
      end else begin
         state        <= state_nxt;
         barpos       <= barpos_nxt;
         holepos      <= holepos_nxt;
         plrpos       <= plrpos_nxt;
         lives        <= lives_nxt;
         cyclesneeded <= cyc_nxt;
         score        <= score_nxt;
         game_over    <= game_over_nxt;
         tick_cnt     <= tick_cnt_nxt;
         pass_cnt     <= pass_cnt_nxt;
         hit_cnt      <= hit_cnt_nxt;
         lfsr         <= lfsr_nxt;
         left_q       <= btn_left;
         right_q      <= btn_right;
         start_q      <= btn_start;
      end
   end

   always_comb begin
      state_nxt     = state;
      barpos_nxt    = barpos;
      holepos_nxt   = holepos;
      plrpos_nxt    = plrpos;
      lives_nxt     = lives;
      cyc_nxt       = cyclesneeded;
      score_nxt     = score;
      game_over_nxt = game_over;
      tick_cnt_nxt  = tick_cnt;
      pass_cnt_nxt  = pass_cnt;
      hit_cnt_nxt   = hit_cnt;
      // x^8+x^6+x^5+x^4+1, free-running in every state
      lfsr_nxt      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

      case (state)
         ST_PLAY: begin
            if (left_rise && !right_rise && plrpos != 4'd0)
               plrpos_nxt = plrpos - 4'd1;
            else if (right_rise && !left_rise && plrpos != PLR_LAST)
               plrpos_nxt = plrpos + 4'd1;

            if (tick) begin
               if (tick_cnt + 3'd1 == cyclesneeded) begin
                  tick_cnt_nxt = 3'd0;
                  barpos_nxt   = bar_step;
                  if (barpos == BAR_LAST)
                     holepos_nxt = new_hole;
                  // Collision uses the player position held before this edge.
                  if (bar_step == COLLIDE_ROW) begin
                     if (plrpos == holepos) begin
                        if (score != 8'hFF)
                           score_nxt = score + 8'd1;
                        if (pass_cnt + 8'd1 == PASS_LIMIT) begin
                           pass_cnt_nxt = 8'd0;
                           if (cyclesneeded > 3'd1)
                              cyc_nxt = cyclesneeded - 3'd1;
                        end else begin
                           pass_cnt_nxt = pass_cnt + 8'd1;
                        end
                     end else if (lives > 2'd1) begin
                        lives_nxt    = lives - 2'd1;
                        pass_cnt_nxt = 8'd0;
                        hit_cnt_nxt  = 8'd0;
                        state_nxt    = ST_HIT;
                     end else begin
                        lives_nxt     = 2'd0;
                        game_over_nxt = 1'b1;
                        state_nxt     = ST_OVER;
                     end
                  end
               end else begin
                  tick_cnt_nxt = tick_cnt + 3'd1;
               end
            end
         end

         ST_HIT: begin
            if (tick) begin
               if (hit_cnt + 8'd1 == HIT_LIMIT) begin
                  hit_cnt_nxt  = 8'd0;
                  barpos_nxt   = 9'd0;
                  holepos_nxt  = new_hole;
                  tick_cnt_nxt = 3'd0;
                  state_nxt    = ST_PLAY;
               end else begin
                  hit_cnt_nxt = hit_cnt + 8'd1;
               end
            end
         end

         ST_OVER: begin
            if (start_rise) begin
               state_nxt     = ST_PLAY;
               barpos_nxt    = 9'd0;
               holepos_nxt   = 4'd0;
               plrpos_nxt    = PLR_HOME;
               lives_nxt     = LIVES_INIT;
               cyc_nxt       = CYC_INIT;
               score_nxt     = 8'd0;
               game_over_nxt = 1'b0;
               tick_cnt_nxt  = 3'd0;
               pass_cnt_nxt  = 8'd0;
               hit_cnt_nxt   = 8'd0;
            end
         end

         default: begin
            state_nxt = ST_PLAY;
         end
      endcase
   end

endmodule
`default_nettype wire
